// File: rtl/componer_desde_digitos_pkg.sv
// Shared definitions for the decimal-formatting blocks.
//   state_t      : FSM encoding for the sequential composer.
//   DIGIT_MAX    : largest legal BCD digit value.
//   mul10_add()  : acc*10 + d built from shifts and adds, truncated to OUT_W_DEF.
package componer_desde_digitos_pkg;

    localparam int OUT_W_DEF   = 32;
    localparam int DIGIT_W_DEF = 5;
    localparam int DIGIT_MAX   = 9;
    // Highest number of digit inputs any instance can wire up.
    localparam int MAX_DIGITS  = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // acc*10 + d as (acc<<3)+(acc<<1)+d; any carry out of OUT_W_DEF is dropped.
    function automatic logic [OUT_W_DEF-1:0] mul10_add(input logic [OUT_W_DEF-1:0]   acc,
                                                       input logic [DIGIT_W_DEF-1:0] d);
        return (acc << 3) + (acc << 1) + OUT_W_DEF'(d);
    endfunction

endpackage

// File: rtl/componer_desde_digitos_if.sv
// Handshake bundle for the decimal-to-binary composer.
//   in_valid/in_ready   : digit-set transfer (digit0 = units .. digit5 = hundred-thousands)
//   out_valid/out_ready : result transfer carrying numero and error
// master = digit source / result consumer, slave = composer.
interface componer_desde_digitos_if #(
    parameter int DIGIT_W = 5,
    parameter int OUT_W   = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [DIGIT_W-1:0] digit0;
    logic [DIGIT_W-1:0] digit1;
    logic [DIGIT_W-1:0] digit2;
    logic [DIGIT_W-1:0] digit3;
    logic [DIGIT_W-1:0] digit4;
    logic [DIGIT_W-1:0] digit5;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   numero;
    logic               error;

    modport master (
        output in_valid, digit0, digit1, digit2, digit3, digit4, digit5, out_ready,
        input  in_ready, out_valid, numero, error
    );

    modport slave (
        input  in_valid, digit0, digit1, digit2, digit3, digit4, digit5, out_ready,
        output in_ready, out_valid, numero, error
    );
endinterface

// File: rtl/componer_desde_digitos.sv
// Sequential decimal-to-binary composer.
// Captures a set of BCD digits in one transfer and rebuilds the binary value by
// Horner evaluation, one digit per clock starting from the most significant.
// Digits above 9 set error and contribute 0; the conversion always completes.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : slave side of componer_desde_digitos_if (digit set in, result out)
// DIGIT_W / OUT_W must match the package defaults used by mul10_add().
module componer_desde_digitos
    import componer_desde_digitos_pkg::*;
#(
    parameter int N_DIGITS = 6,
    parameter int DIGIT_W  = DIGIT_W_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    componer_desde_digitos_if.slave  bus
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    state_t                             state_q, state_d;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]   dig_q;
    logic [OUT_W-1:0]                   acc_q, acc_nxt;
    logic                               err_q, err_nxt;
    logic [IDX_W-1:0]                   idx_q;
    logic [OUT_W-1:0]                   numero_q;
    logic                               error_q;

    // Only six digit inputs exist; positions beyond them read as zero.
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0] din_all;
    assign din_all = {{((MAX_DIGITS-6)*DIGIT_W){1'b0}},
                      bus.digit5, bus.digit4, bus.digit3,
                      bus.digit2, bus.digit1, bus.digit0};

    logic [DIGIT_W-1:0] d_cur, d_use;
    logic               d_bad;

    // Digit selected by idx, sanitized, then folded into the accumulator.
    always_comb begin
        d_cur = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (idx_q == IDX_W'(i)) d_cur = dig_q[i];
        d_bad   = (d_cur > DIGIT_W'(DIGIT_MAX));
        d_use   = d_bad ? '0 : d_cur;
        acc_nxt = mul10_add(acc_q, d_use);
        err_nxt = err_q | d_bad;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)   state_d = CONVERT;
            CONVERT: if (idx_q == '0)    state_d = DONE;
            DONE:    if (bus.out_ready)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dig_q    <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            numero_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    for (int i = 0; i < N_DIGITS; i++) dig_q[i] <= din_all[i];
                    acc_q <= '0;
                    err_q <= 1'b0;
                    idx_q <= IDX_W'(N_DIGITS - 1);
                end
                CONVERT: begin
                    acc_q <= acc_nxt;
                    err_q <= err_nxt;
                    if (idx_q == '0) begin
                        numero_q <= acc_nxt;
                        error_q  <= err_nxt;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.numero    = numero_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_componer_desde_digitos.sv
// Directed self-checking bench for componer_desde_digitos (N_DIGITS=6).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_componer_desde_digitos;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    componer_desde_digitos_if #(.DIGIT_W(5), .OUT_W(32)) bus ();

    componer_desde_digitos #(.N_DIGITS(6), .DIGIT_W(5), .OUT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int          acc_cyc[$];
    logic [31:0] res_q[$];
    logic        res_err[$];

    // Log every accepted set and every delivered result.
    always @(posedge clk) begin
        cyc++;
        if (!reset && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (!reset && bus.out_valid && bus.out_ready) begin
            res_q.push_back(bus.numero);
            res_err.push_back(bus.error);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input int d5, input int d4, input int d3,
                             input int d2, input int d1, input int d0);
        bus.digit5 = 5'(d5); bus.digit4 = 5'(d4); bus.digit3 = 5'(d3);
        bus.digit2 = 5'(d2); bus.digit1 = 5'(d1); bus.digit0 = 5'(d0);
    endtask

    task automatic drive_val(input int v);
        drive_raw((v / 100000) % 10, (v / 10000) % 10, (v / 1000) % 10,
                  (v / 100) % 10, (v / 10) % 10, v % 10);
    endtask

    // One full transfer with out_ready high; digits must already be driven.
    task automatic convert(input string tag, input logic [31:0] exp, input logic experr);
        int c;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();                         // accept edge E0
        bus.in_valid = 1'b0;
        c = 0;
        while (!bus.out_valid && c < 20) begin
            tick();
            c++;
        end
        check({tag, "_latency"}, 32'(c), 32'd6);
        check({tag, "_numero"}, bus.numero, exp);
        check({tag, "_error"}, 32'(bus.error), 32'(experr));
        tick();                         // output transfer edge
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n0, r0, c;
        logic [31:0] held_num;
        logic        seen_ov;
        int          vals[3];

        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_val(0);
        repeat (3) tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_numero", bus.numero, 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        tick();

        // Basic compositions, including the digit-range extremes.
        drive_raw(1, 2, 3, 4, 5, 6); convert("v123456", 32'd123456, 1'b0);
        drive_val(0);                convert("zeros",   32'd0,      1'b0);
        drive_val(999999);           convert("nines",   32'd999999, 1'b0);
        drive_raw(1, 2, 12, 4, 5, 6); convert("bad_d3", 32'd120456, 1'b1);

        // Backpressure in DONE: result frozen, no new set taken.
        n0 = acc_cyc.size();
        drive_val(700001);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_numero0", bus.numero, 32'd700001);
        held_num = bus.numero;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = ~bus.in_valid;
            drive_val(111111 * (k + 1));
            tick();
            check("bp_hold_numero", bus.numero, held_num);
            check("bp_hold_error", 32'(bus.error), 32'd0);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_released", 32'(bus.out_valid), 32'd0);
        check("bp_one_accept", 32'(acc_cyc.size() - n0), 32'd1);

        // Reset in the middle of a conversion discards it.
        r0 = res_q.size();
        drive_val(555555);
        bus.in_valid = 1'b1;
        tick();                         // E0
        bus.in_valid = 1'b0;
        tick();                         // E1
        tick();                         // E2
        reset = 1'b1;
        tick();                         // E3 with reset
        reset = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_numero", bus.numero, 32'd0);
        seen_ov = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) seen_ov = 1'b1;
            tick();
        end
        check("mid_rst_no_out", 32'(seen_ov), 32'd0);
        check("mid_rst_no_result", 32'(res_q.size() - r0), 32'd0);
        drive_raw(0, 0, 0, 0, 4, 2); convert("after_rst", 32'd42, 1'b0);

        // Back-to-back sets with in_valid held high.
        vals[0] = 314159; vals[1] = 271828; vals[2] = 100000;
        n0 = acc_cyc.size();
        r0 = res_q.size();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_val(vals[k]);
            c = 0;
            while (acc_cyc.size() < n0 + k + 1 && c < 30) begin
                tick();
                c++;
            end
            check("b2b_accept_timeout", 32'(acc_cyc.size() >= n0 + k + 1), 32'd1);
        end
        bus.in_valid = 1'b0;
        c = 0;
        while (res_q.size() < r0 + 3 && c < 40) begin
            tick();
            c++;
        end
        check("b2b_result_count", 32'(res_q.size() - r0), 32'd3);
        if (res_q.size() >= r0 + 3 && acc_cyc.size() >= n0 + 3) begin
            for (int k = 0; k < 3; k++) begin
                check("b2b_numero", res_q[r0 + k], 32'(vals[k]));
                check("b2b_error", 32'(res_err[r0 + k]), 32'd0);
            end
            check("b2b_period01", 32'(acc_cyc[n0 + 1] - acc_cyc[n0]), 32'd8);
            check("b2b_period12", 32'(acc_cyc[n0 + 2] - acc_cyc[n0 + 1]), 32'd8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
